// File: rtl/stoch_decoder_if.sv
// -----------------------------------------------------------------------------
// stoch_decoder_if
//
// Purpose : bundles the control, bitstream and result signals of the
//           stochastic bitstream decoder into one interface.
//
// Signals : start        request to begin a new conversion window
//           abort        synchronous cancel of the current window
//           bit_in       stochastic bitstream sample
//           bit_valid    qualifies bit_in for the current cycle
//           result_ack   consumer acknowledge of result
//           busy         high while a window is being accumulated
//           result       count of ones in the last completed window
//           result_valid high while result is new and unacknowledged
//
// Modports: master  - the producer/consumer side driving the decoder
//           slave   - the decoder itself
// -----------------------------------------------------------------------------
interface stoch_decoder_if #(
   parameter int WIDTH = 10
);

   logic             start;
   logic             abort;
   logic             bit_in;
   logic             bit_valid;
   logic             result_ack;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             result_valid;

   modport master (
      output start,
      output abort,
      output bit_in,
      output bit_valid,
      output result_ack,
      input  busy,
      input  result,
      input  result_valid
   );

   modport slave (
      input  start,
      input  abort,
      input  bit_in,
      input  bit_valid,
      input  result_ack,
      output busy,
      output result,
      output result_valid
   );

endinterface

// File: rtl/stoch_decoder.sv
// -----------------------------------------------------------------------------
// stoch_decoder
//
// Purpose : converts a stochastic (unipolar) bitstream into a binary value by
//           counting the ones in a window of WINDOW = 2^WIDTH - 1 valid
//           samples, i.e. one full period of a maximal-length WIDTH-bit LFSR.
//
// Ports   : clk    single clock, all state changes on its rising edge
//           rst_n  asynchronous active-low reset
//           bus    stoch_decoder_if.slave
//                    start, abort, bit_in, bit_valid, result_ack  (inputs)
//                    busy, result, result_valid                   (outputs)
//
// States  : IDLE  - waiting for start; bitstream and ack are ignored
//           ACCUM - counting valid samples and ones
//           DONE  - result held until acknowledged or aborted
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module stoch_decoder #(
   parameter int WIDTH = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   stoch_decoder_if.slave    bus
);

   // State encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Sample index of the final bit of a window (WINDOW - 1). WINDOW itself is
   // all ones, so the last index is all ones with the LSB cleared.
   localparam logic [WIDTH-1:0] LAST_IDX = {{(WIDTH-1){1'b1}}, 1'b0};

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   logic [1:0]       state_q;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] ones_q;
   logic [WIDTH-1:0] ones_nxt;
   logic [WIDTH-1:0] samp_q;
   logic [WIDTH-1:0] samp_nxt;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_nxt;
   logic             result_valid_q;
   logic             result_valid_nxt;
   logic             busy_q;
   logic             busy_nxt;

   // Ones count including the bit presented this cycle. The window length is
   // 2^WIDTH - 1, so this sum can never exceed the counter range.
   logic [WIDTH-1:0] ones_plus_bit;
   logic             last_sample;

   assign ones_plus_bit = ones_q + {{(WIDTH-1){1'b0}}, bus.bit_in};
   assign last_sample   = (samp_q == LAST_IDX);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt        = state_q;
      ones_nxt         = ones_q;
      samp_nxt         = samp_q;
      result_nxt       = result_q;
      result_valid_nxt = result_valid_q;

      case (state_q)
         ST_IDLE: begin
            // The bit presented alongside start is deliberately not counted:
            // counters are cleared, not loaded.
            if (bus.start) begin
               state_nxt = ST_ACCUM;
               ones_nxt  = '0;
               samp_nxt  = '0;
            end
         end

         ST_ACCUM: begin
            // abort wins over a simultaneous final bit: result is untouched.
            if (bus.abort) begin
               state_nxt = ST_IDLE;
            end else if (bus.bit_valid) begin
               ones_nxt = ones_plus_bit;
               samp_nxt = samp_q + 1'b1;
               if (last_sample) begin
                  state_nxt        = ST_DONE;
                  result_nxt       = ones_plus_bit;
                  result_valid_nxt = 1'b1;
               end
            end
         end

         ST_DONE: begin
            if (bus.abort) begin
               state_nxt        = ST_IDLE;
               result_valid_nxt = 1'b0;
            end else if (bus.result_ack) begin
               result_valid_nxt = 1'b0;
               if (bus.start) begin
                  // Back-to-back window: go straight to counting.
                  state_nxt = ST_ACCUM;
                  ones_nxt  = '0;
                  samp_nxt  = '0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end

         default: begin
            state_nxt        = ST_IDLE;
            ones_nxt         = '0;
            samp_nxt         = '0;
            result_valid_nxt = 1'b0;
         end
      endcase

      // busy is registered, so it is derived from the state being entered.
      busy_nxt = (state_nxt == ST_ACCUM);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         ones_q         <= '0;
         samp_q         <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_nxt;
         ones_q         <= ones_nxt;
         samp_q         <= samp_nxt;
         result_q       <= result_nxt;
         result_valid_q <= result_valid_nxt;
         busy_q         <= busy_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.busy         = busy_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_stoch_decoder.sv
// -----------------------------------------------------------------------------
// tb_stoch_decoder
//
// Self-checking bench for stoch_decoder. Expected results come from a
// reference that simply sums the ones held in a queue of window bits.
// -----------------------------------------------------------------------------
module tb_stoch_decoder;

   localparam int WIDTH  = 10;
   localparam int WINDOW = 1023;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   stoch_decoder_if #(.WIDTH(WIDTH)) bus ();

   stoch_decoder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   bit stream[$];

   // --------------------------------------------------------------------------
   // Stimulus helpers (no checking inside)
   // --------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.bit_in     = 1'b0;
      bus.bit_valid  = 1'b0;
      bus.result_ack = 1'b0;
   endtask

   // Start cycle also presents a valid bit, which must not be counted.
   task automatic do_start(input logic b);
      bus.start     = 1'b1;
      bus.bit_valid = 1'b1;
      bus.bit_in    = b;
      tick();
      idle_inputs();
   endtask

   task automatic do_ack();
      bus.result_ack = 1'b1;
      tick();
      bus.result_ack = 1'b0;
   endtask

   function automatic int model_sum();
      int s = 0;
      foreach (stream[i]) s += int'(stream[i]);
      return s;
   endfunction

   // Feeds the queued bits with optional random gaps and random start noise.
   // first_rv is the cycle count (from the first fed cycle) at which
   // result_valid was first seen high, 0 if never.
   task automatic drive_queue(input int gap_pct, input bit start_noise,
                              input bit abort_last,
                              output int gaps, output int first_rv);
      int cyc = 0;
      gaps     = 0;
      first_rv = 0;
      for (int i = 0; i < stream.size(); i++) begin
         for (int g = 0; g < 3; g++) begin
            if (int'($urandom_range(99)) >= gap_pct) break;
            bus.bit_valid = 1'b0;
            bus.bit_in    = 1'($urandom);
            bus.start     = start_noise ? 1'($urandom) : 1'b0;
            tick();
            cyc++;
            gaps++;
            if (bus.result_valid && first_rv == 0) first_rv = cyc;
         end
         bus.bit_valid = 1'b1;
         bus.bit_in    = stream[i];
         bus.start     = start_noise ? 1'($urandom) : 1'b0;
         bus.abort     = (abort_last && i == stream.size() - 1);
         tick();
         cyc++;
         if (bus.result_valid && first_rv == 0) first_rv = cyc;
      end
      idle_inputs();
   endtask

   // --------------------------------------------------------------------------
   // Tests
   // --------------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #3;
      checks++;
      if (bus.busy !== 1'b0 || bus.result !== '0 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b result=%0d rv=%b, required 0/0/0",
                  bus.busy, bus.result, bus.result_valid);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: busy=%b rv=%b, required 0/0", bus.busy, bus.result_valid);
      end
   endtask

   task automatic test_all_ones();
      int gaps, first_rv;
      stream.delete();
      for (int i = 0; i < WINDOW; i++) stream.push_back(1'b1);
      do_start(1'b1);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL ones_busy: got %b required 1", bus.busy);
      end
      drive_queue(0, 1'b0, 1'b0, gaps, first_rv);
      checks++;
      if (first_rv != WINDOW) begin
         errors++;
         $display("FAIL ones_rv_timing: rv first at cycle %0d required %0d", first_rv, WINDOW);
      end
      checks++;
      if (bus.result !== 10'(model_sum()) || bus.result_valid !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ones_result: result=%0d rv=%b busy=%b required %0d/1/0",
                  bus.result, bus.result_valid, bus.busy, model_sum());
      end
      // In DONE: start without ack and bit_valid are ignored.
      bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      idle_inputs();
      checks++;
      if (bus.result !== 10'd1023 || bus.result_valid !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL done_hold: result=%0d rv=%b busy=%b required 1023/1/0",
                  bus.result, bus.result_valid, bus.busy);
      end
      do_ack();
      checks++;
      if (bus.result !== 10'd1023 || bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ones_ack: result=%0d rv=%b busy=%b required 1023/0/0",
                  bus.result, bus.result_valid, bus.busy);
      end
      // In IDLE: bitstream and ack are ignored.
      bus.bit_valid = 1'b1; bus.bit_in = 1'b1; bus.result_ack = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      idle_inputs();
      checks++;
      if (bus.result !== 10'd1023 || bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore: result=%0d rv=%b busy=%b required 1023/0/0",
                  bus.result, bus.result_valid, bus.busy);
      end
   endtask

   task automatic test_gaps_zeros();
      int gaps, first_rv;
      stream.delete();
      for (int i = 0; i < WINDOW; i++) stream.push_back(1'b0);
      do_start(1'b1);
      drive_queue(30, 1'b1, 1'b0, gaps, first_rv);
      checks++;
      if (first_rv != WINDOW + gaps) begin
         errors++;
         $display("FAIL gaps_timing: rv first at cycle %0d required %0d", first_rv, WINDOW + gaps);
      end
      checks++;
      if (bus.result !== 10'd0 || bus.result_valid !== 1'b1) begin
         errors++;
         $display("FAIL gaps_zero_result: result=%0d rv=%b required 0/1", bus.result, bus.result_valid);
      end
      do_ack();
   endtask

   task automatic test_random_bits();
      int gaps, first_rv;
      for (int r = 0; r < 2; r++) begin
         stream.delete();
         for (int i = 0; i < WINDOW; i++) stream.push_back(1'($urandom));
         do_start(1'($urandom));
         drive_queue(20, 1'b1, 1'b0, gaps, first_rv);
         checks++;
         if (bus.result !== 10'(model_sum()) || bus.result_valid !== 1'b1 || first_rv != WINDOW + gaps) begin
            errors++;
            $display("FAIL random_%0d: result=%0d rv=%b at %0d required %0d/1 at %0d",
                     r, bus.result, bus.result_valid, first_rv, model_sum(), WINDOW + gaps);
         end
         do_ack();
      end
   endtask

   task automatic test_lfsr();
      int vals[3] = '{512, 1, 1023};
      int want[3] = '{511, 0, 1022};
      int gaps, first_rv;
      logic [9:0] l;
      for (int k = 0; k < 3; k++) begin
         stream.delete();
         l = 10'd1;
         for (int i = 0; i < WINDOW; i++) begin
            stream.push_back(int'(l) < vals[k]);
            l = {l[8:0], l[9] ^ l[6]};
         end
         do_start(1'b0);
         drive_queue(10, 1'b0, 1'b0, gaps, first_rv);
         checks++;
         if (bus.result !== 10'(want[k]) || bus.result_valid !== 1'b1) begin
            errors++;
            $display("FAIL lfsr_v%0d: result=%0d rv=%b required %0d/1",
                     vals[k], bus.result, bus.result_valid, want[k]);
         end
         do_ack();
      end
   endtask

   task automatic test_abort();
      int gaps, first_rv;
      logic [WIDTH-1:0] prev = 10'd1022;   // last acknowledged LFSR result
      stream.delete();
      for (int i = 0; i < 500; i++) stream.push_back(1'b1);
      do_start(1'b1);
      drive_queue(0, 1'b0, 1'b0, gaps, first_rv);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      tick(); tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== prev) begin
         errors++;
         $display("FAIL abort_mid: busy=%b rv=%b result=%0d required 0/0/%0d",
                  bus.busy, bus.result_valid, bus.result, prev);
      end
      // abort together with the final valid bit
      stream.delete();
      for (int i = 0; i < WINDOW; i++) stream.push_back(1'b1);
      do_start(1'b1);
      drive_queue(0, 1'b0, 1'b1, gaps, first_rv);
      checks++;
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== prev || first_rv != 0) begin
         errors++;
         $display("FAIL abort_last_bit: busy=%b rv=%b result=%0d required 0/0/%0d",
                  bus.busy, bus.result_valid, bus.result, prev);
      end
      do_start(1'b1);
      drive_queue(0, 1'b0, 1'b0, gaps, first_rv);
      checks++;
      if (bus.result !== 10'd1023 || bus.result_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_restart: result=%0d rv=%b required 1023/1", bus.result, bus.result_valid);
      end
      // abort in DONE beats start
      bus.abort = 1'b1; bus.start = 1'b1; bus.result_ack = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 10'd1023) begin
         errors++;
         $display("FAIL abort_done: rv=%b busy=%b result=%0d required 0/0/1023",
                  bus.result_valid, bus.busy, bus.result);
      end
   endtask

   task automatic test_reset_mid();
      int gaps, first_rv;
      stream.delete();
      for (int i = 0; i < 300; i++) stream.push_back(1'b1);
      do_start(1'b1);
      drive_queue(0, 1'b0, 1'b0, gaps, first_rv);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.result !== '0 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_async: busy=%b result=%0d rv=%b required 0/0/0",
                  bus.busy, bus.result, bus.result_valid);
      end
      tick();
      rst_n = 1'b1;
      tick(); tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_idle: busy=%b rv=%b required 0/0", bus.busy, bus.result_valid);
      end
      stream.delete();
      for (int i = 0; i < WINDOW; i++) stream.push_back(i % 2 == 0);
      do_start(1'b0);
      drive_queue(15, 1'b0, 1'b0, gaps, first_rv);
      checks++;
      if (bus.result !== 10'd512 || bus.result_valid !== 1'b1) begin
         errors++;
         $display("FAIL alternating: result=%0d rv=%b required 512/1", bus.result, bus.result_valid);
      end
   endtask

   task automatic test_back_to_back();
      int gaps, first_rv;
      // Enters with a pending result (512) in DONE.
      bus.result_ack = 1'b1;
      bus.start      = 1'b1;
      bus.bit_valid  = 1'b1;
      bus.bit_in     = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_handover: rv=%b busy=%b required 0/1", bus.result_valid, bus.busy);
      end
      stream.delete();
      for (int i = 0; i < WINDOW; i++) stream.push_back(1'($urandom));
      drive_queue(25, 1'b1, 1'b0, gaps, first_rv);
      checks++;
      if (bus.result !== 10'(model_sum()) || bus.result_valid !== 1'b1 || first_rv != WINDOW + gaps) begin
         errors++;
         $display("FAIL b2b_second_window: result=%0d rv=%b at %0d required %0d/1 at %0d",
                  bus.result, bus.result_valid, first_rv, model_sum(), WINDOW + gaps);
      end
      do_ack();
      checks++;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ack: rv=%b busy=%b required 0/0", bus.result_valid, bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_gaps_zeros();
      test_random_bits();
      test_lfsr();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stoch_decoder.md
STOCH_DECODER -- requirements
Module: stoch_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, meaning the result width; the window length SHALL be WINDOW = 2^WIDTH - 1 (1023 at default), equal to one maximal-length LFSR period.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a new conversion window.
REQ-005 abort  input  1  synchronous cancel of the current window.
REQ-006 bit_in  input  1  stochastic bitstream sample.
REQ-007 bit_valid  input  1  qualifies bit_in for the current cycle.
REQ-008 result_ack  input  1  consumer acknowledge of result.
REQ-009 busy  output  1  high while in ACCUM.
REQ-010 result  output  WIDTH  count of ones in the last completed window.
REQ-011 result_valid  output  1  high while result is new and unacknowledged.

Function
REQ-012 The block SHALL implement three states: IDLE, ACCUM and DONE; all outputs SHALL be registered.
REQ-013 In IDLE, start=1 SHALL move the block to ACCUM on the next edge and clear the ones counter and sample counter; a bit presented in the start cycle SHALL NOT be counted.
REQ-014 In IDLE, bit_valid, bit_in and result_ack SHALL be ignored.
REQ-015 In ACCUM, each cycle with bit_valid=1 SHALL increment the sample counter by 1 and add bit_in to the ones counter; cycles with bit_valid=0 SHALL leave both counters unchanged.
REQ-016 On the edge accepting the WINDOW-th valid bit, the block SHALL move to DONE, load result with the final ones count including that bit, and set result_valid=1 on that same edge.
REQ-017 The ones counter SHALL be WIDTH bits wide and SHALL never wrap, because its maximum value is WINDOW.
REQ-018 In ACCUM, start SHALL be ignored.
REQ-019 In ACCUM, abort=1 SHALL return the block to IDLE on the next edge with result and result_valid unchanged; abort SHALL take priority over a simultaneous final valid bit.
REQ-020 In DONE, result and result_valid SHALL be held stable, and bit_valid SHALL be ignored.
REQ-021 In DONE, result_ack=1 with start=0 SHALL clear result_valid and move to IDLE on the next edge; result SHALL retain its value.
REQ-022 In DONE, result_ack=1 together with start=1 SHALL clear result_valid, clear both counters and move directly to ACCUM (back-to-back windows).
REQ-023 In DONE, start without result_ack SHALL be ignored.
REQ-024 In DONE, abort=1 SHALL clear result_valid and move to IDLE; abort SHALL take priority over start.
REQ-025 In ACCUM, busy SHALL be 1; in IDLE and DONE, busy SHALL be 0.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, both counters 0, result 0, result_valid 0 and busy 0, independent of clk.
REQ-027 Reset asserted mid-ACCUM or in DONE SHALL discard the partial or pending result; after release, the block SHALL wait in IDLE for start.
REQ-028 The first rising edge after rst_n deasserts SHALL be treated as a normal IDLE cycle.

Verification
REQ-029 Reset, start, then 1023 cycles of bit_valid=1, bit_in=1 -> result=1023, result_valid=1 one edge after the last bit, busy=0; ack -> result_valid=0, result holds 1023.
REQ-030 Start, then 1023 valid zeros interleaved with random bit_valid=0 gaps -> result=0, asserted only after the 1023rd valid bit; total cycle count equals 1023 plus the gap count.
REQ-031 LFSR (x^10+x^7+1, seed 1) compared against value v=512 (bit=lfsr<v) feeding 1023 valid bits -> result=511; repeat with v=1 -> result 0, and v=1023 -> result 1022.
REQ-032 Abort after 500 valid bits -> IDLE, result_valid stays 0; restart with 1023 ones -> 1023.
REQ-033 rst_n pulsed low mid-ACCUM after 300 ones -> all outputs 0 immediately; a new window of 1023 alternating bits starting with 1 -> 512.
REQ-034 In DONE, result_ack and start in the same cycle -> result_valid falls, busy rises next edge, and the second window's result is correct with no lost or double-counted bit.
